// File: rtl/amiga_kbd_tx.sv
// rtl/amiga_kbd_tx.sv - Amiga keyboard serial transmitter (event FIFO, KCLK/KDAT shifter, handshake, resync)
// Optional power-up 0xFD/0xFE announcement: AMIGA_KBD_POWERUP_EN
module amiga_kbd_tx #(
    parameter int unsigned CLK_KHZ    = 28375,
    parameter int unsigned PHASE_US   = 20,
    parameter int unsigned TIMEOUT_MS = 143,
    parameter int unsigned FIFO_AW    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ev_level,
    input  logic [1:0]         ev_type,
    input  logic [7:0]         ev_data,
    input  logic               kbd_dat_in,
    output logic               kbd_dat_oe,
    output logic               kbd_clk_oe,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow
);

    localparam int unsigned PH      = CLK_KHZ * PHASE_US / 1000;
    localparam int unsigned TO      = CLK_KHZ * TIMEOUT_MS;
    localparam int unsigned HS_MIN  = (CLK_KHZ / 1000 > 0) ? CLK_KHZ / 1000 : 1;
    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned TMR_W   = $clog2((TO > PH) ? TO : PH) + 1;
    localparam int unsigned HS_W    = $clog2(HS_MIN + 1);
    // Released KDAT needs the synchroniser latency to read high before handshake sampling.
    localparam int unsigned REL_CYC = 3;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_SETUP, S_CLK_LO, S_CLK_HI, S_REL, S_HS_WAIT, S_HS_END, S_GAP
    } state_t;

    state_t r_state, w_next;

    logic               r_dat_s1, r_dat_s2;
    logic               r_ev_copy;
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow, r_ovf_pending;
    logic               r_resync_pending, r_retry_valid, r_cur_resync;
    logic [7:0]         r_retry_byte, r_cur_byte, r_shift;
    logic [2:0]         r_bit_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic [HS_W-1:0]    r_low_cnt;

    logic w_ev_new, w_push_req, w_full, w_pop, w_push_ok, w_drop, w_have;
    logic w_sel_resync, w_sel_retry, w_sel_pwr, w_sel_ovf, w_sel_fifo;
    logic w_pwr_due;
    logic [7:0] w_pwr_byte, w_sel_byte;
    logic w_tmr_clr, w_load, w_bit_adv, w_timeout;
    logic w_ph_end, w_to_end, w_hs_ok;

    assign w_ev_new   = (ev_level != r_ev_copy);
    assign w_push_req = w_ev_new && (ev_type == 2'd2);
    assign w_full     = (r_count == (FIFO_AW+1)'(DEPTH));
    assign w_pop      = w_load && w_sel_fifo;
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

`ifdef AMIGA_KBD_POWERUP_EN
    logic [1:0] r_pwr_step;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_pwr_step <= 2'd0;
        else if (w_load && w_sel_pwr)
            r_pwr_step <= r_pwr_step + 2'd1;
    end
    assign w_pwr_due  = (r_pwr_step != 2'd2);
    assign w_pwr_byte = (r_pwr_step == 2'd0) ? 8'hFD : 8'hFE;
`else
    assign w_pwr_due  = 1'b0;
    assign w_pwr_byte = 8'hFD;
`endif

    assign w_have = r_resync_pending || r_retry_valid || w_pwr_due || r_ovf_pending || (r_count != '0);

    always_comb begin
        w_sel_resync = 1'b0;
        w_sel_retry  = 1'b0;
        w_sel_pwr    = 1'b0;
        w_sel_ovf    = 1'b0;
        w_sel_fifo   = 1'b0;
        w_sel_byte   = r_mem[r_rd_ptr];
        if (r_resync_pending) begin
            w_sel_resync = 1'b1;
            w_sel_byte   = 8'hF9;
        end else if (r_retry_valid) begin
            w_sel_retry  = 1'b1;
            w_sel_byte   = r_retry_byte;
        end else if (w_pwr_due) begin
            w_sel_pwr    = 1'b1;
            w_sel_byte   = w_pwr_byte;
        end else if (r_ovf_pending) begin
            w_sel_ovf    = 1'b1;
            w_sel_byte   = 8'hFA;
        end else begin
            w_sel_fifo   = (r_count != '0);
        end
    end

    assign w_ph_end = (r_timer == TMR_W'(PH - 1));
    assign w_to_end = (r_timer == TMR_W'(TO - 1));
    assign w_hs_ok  = !r_dat_s2 && (r_low_cnt >= HS_W'(HS_MIN - 1));

    always_comb begin
        w_next     = r_state;
        w_tmr_clr  = 1'b0;
        w_load     = 1'b0;
        w_bit_adv  = 1'b0;
        w_timeout  = 1'b0;
        kbd_dat_oe = 1'b0;
        kbd_clk_oe = 1'b0;
        case (r_state)
            S_IDLE: if (w_have) begin
                w_next = S_LOAD; w_tmr_clr = 1'b1;
            end
            S_LOAD: begin
                w_load = 1'b1; w_next = S_SETUP; w_tmr_clr = 1'b1;
            end
            S_SETUP: begin
                kbd_dat_oe = r_shift[7];
                if (w_ph_end) begin w_next = S_CLK_LO; w_tmr_clr = 1'b1; end
            end
            S_CLK_LO: begin
                kbd_dat_oe = r_shift[7];
                kbd_clk_oe = 1'b1;
                if (w_ph_end) begin w_next = S_CLK_HI; w_tmr_clr = 1'b1; end
            end
            S_CLK_HI: begin
                kbd_dat_oe = r_shift[7];
                if (w_ph_end) begin
                    w_bit_adv = 1'b1;
                    w_tmr_clr = 1'b1;
                    w_next    = (r_bit_cnt == 3'd7) ? S_REL : S_SETUP;
                end
            end
            S_REL: if (r_timer == TMR_W'(REL_CYC - 1)) begin
                w_next = S_HS_WAIT; w_tmr_clr = 1'b1;
            end
            S_HS_WAIT: begin
                if (w_hs_ok) begin
                    w_next = S_HS_END;
                end else if (w_to_end) begin
                    // Timeout: clock out a lone '1' bit, then wait again with a fresh timeout.
                    w_timeout = 1'b1; w_next = S_SETUP; w_tmr_clr = 1'b1;
                end
            end
            S_HS_END: if (r_dat_s2) begin
                w_next = S_GAP; w_tmr_clr = 1'b1;
            end
            S_GAP: if (w_ph_end) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy       = (r_state != S_IDLE);
    assign fifo_level = r_count;
    assign overflow   = r_overflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_low_cnt <= '0;
            r_dat_s1  <= 1'b1;
            r_dat_s2  <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_timer  <= w_tmr_clr ? '0 : r_timer + 1'b1;
            r_dat_s1 <= kbd_dat_in;
            r_dat_s2 <= r_dat_s1;
            if (r_state == S_HS_WAIT && !r_dat_s2) begin
                if (r_low_cnt != {HS_W{1'b1}})
                    r_low_cnt <= r_low_cnt + 1'b1;
            end else begin
                r_low_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= ev_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ev_copy     <= 1'b0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_overflow    <= 1'b0;
            r_ovf_pending <= 1'b0;
        end else begin
            if (w_ev_new)
                r_ev_copy <= ev_level;
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop)
                r_count <= r_count - 1'b1;
            r_overflow <= w_drop;
            if (w_load && w_sel_ovf)
                r_ovf_pending <= 1'b0;
            if (w_drop)
                r_ovf_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_resync_pending <= 1'b0;
            r_retry_valid    <= 1'b0;
            r_retry_byte     <= 8'h00;
            r_cur_byte       <= 8'h00;
            r_cur_resync     <= 1'b0;
            r_shift          <= 8'h00;
            r_bit_cnt        <= 3'd0;
        end else begin
            if (w_load) begin
                r_cur_byte   <= w_sel_byte;
                r_shift      <= {w_sel_byte[6:0], w_sel_byte[7]};
                r_bit_cnt    <= 3'd0;
                r_cur_resync <= w_sel_resync;
                if (w_sel_resync)
                    r_resync_pending <= 1'b0;
                if (w_sel_retry)
                    r_retry_valid <= 1'b0;
            end
            if (w_bit_adv) begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_timeout) begin
                r_shift          <= 8'h80;
                r_bit_cnt        <= 3'd7;
                r_resync_pending <= 1'b1;
                // A timed-out 0xF9 must not overwrite the byte still owed to the host.
                if (!r_cur_resync) begin
                    r_retry_valid <= 1'b1;
                    r_retry_byte  <= r_cur_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_amiga_kbd_tx.sv
// tb/tb_amiga_kbd_tx.sv - self-checking bench for amiga_kbd_tx with a host-side KCLK/KDAT model
module tb_amiga_kbd_tx;

    logic       clk = 1'b0;
    logic       reset_n, ev_level, kbd_dat_in;
    logic [1:0] ev_type;
    logic [7:0] ev_data;
    logic       kbd_dat_oe, kbd_clk_oe, busy, overflow;
    logic [3:0] fifo_level;
    logic       host_pull;

    always #5 clk = ~clk;

    assign kbd_dat_in = ~(kbd_dat_oe | host_pull);

    amiga_kbd_tx #(.CLK_KHZ(1000), .PHASE_US(20), .TIMEOUT_MS(1), .FIFO_AW(3)) dut (
        .clk(clk), .reset_n(reset_n), .ev_level(ev_level), .ev_type(ev_type),
        .ev_data(ev_data), .kbd_dat_in(kbd_dat_in), .kbd_dat_oe(kbd_dat_oe),
        .kbd_clk_oe(kbd_clk_oe), .busy(busy), .fifo_level(fifo_level), .overflow(overflow)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] rx_q[$];
    logic [7:0] h_bits;
    int  h_nbits, lo_cnt, lo_min, lo_max, ack_cnt, pull_cnt, man_done, resync_cnt, ovf_cnt;
    logic last_bit, prev_clk;
    bit  auto_ack;
    int  man_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Amiga wire format: rotate left, MSB first.
    function automatic logic [7:0] wire_byte(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction

    // Host: samples KDAT on each KCLK falling edge, measures KCLK-low widths, acks bytes.
    initial begin : host
        bit start_pull;
        host_pull = 1'b0; h_bits = 8'h00; h_nbits = 0; lo_cnt = 0; lo_min = 1000000; lo_max = 0;
        ack_cnt = 0; pull_cnt = 0; man_done = 0; resync_cnt = 0; ovf_cnt = 0;
        last_bit = 1'b0; prev_clk = 1'b0;
        forever begin
            @(negedge clk);
            start_pull = 1'b0;
            if (overflow === 1'b1) ovf_cnt++;
            if (reset_n !== 1'b1) begin
                h_nbits = 0; ack_cnt = 0; pull_cnt = 0; host_pull = 1'b0; prev_clk = 1'b0; lo_cnt = 0;
            end else begin
                if (kbd_clk_oe && !prev_clk) begin
                    h_bits = {h_bits[6:0], kbd_dat_oe};
                    last_bit = kbd_dat_oe;
                    h_nbits++;
                    if (h_nbits == 8) begin
                        rx_q.push_back(h_bits);
                        h_nbits = 0;
                        if (auto_ack) ack_cnt = 50;
                    end
                end
                if (kbd_clk_oe) lo_cnt++;
                else if (prev_clk) begin
                    if (lo_cnt < lo_min) lo_min = lo_cnt;
                    if (lo_cnt > lo_max) lo_max = lo_cnt;
                    lo_cnt = 0;
                end
                prev_clk = kbd_clk_oe;
                if (pull_cnt > 0) begin
                    pull_cnt--;
                    if (pull_cnt == 0) host_pull = 1'b0;
                end else if (ack_cnt > 0) begin
                    ack_cnt--;
                    if (ack_cnt == 0) start_pull = 1'b1;
                end else if (man_req != man_done) begin
                    man_done++;
                    start_pull = 1'b1;
                end
                if (start_pull) begin
                    if (h_nbits != 0) resync_cnt++;
                    h_nbits = 0;
                    host_pull = 1'b1;
                    pull_cnt = 5;
                end
            end
        end
    end

    task automatic send_ev(input logic [1:0] t, input logic [7:0] d);
        @(negedge clk);
        ev_type = t;
        ev_data = d;
        ev_level = ~ev_level;
    endtask

    task automatic wait_drain(input string name);
        int idle = 0;
        for (int i = 0; i < 20000 && idle < 100; i++) begin
            @(negedge clk);
            if (!busy && fifo_level == 0 && ack_cnt == 0 && pull_cnt == 0) idle++;
            else idle = 0;
        end
        check({name, "_drain"}, (idle >= 100), 1);
    endtask

    task automatic wait_rx(input string name, input int n);
        for (int i = 0; i < 3000 && rx_q.size() < n; i++) @(negedge clk);
        check({name, "_rx_wait"}, (rx_q.size() >= n), 1);
    endtask

    task automatic check_seq(input string name, input int base, input logic [7:0] exp[$]);
        logic [7:0] a;
        check({name, "_count"}, rx_q.size() - base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            a = (base + i < rx_q.size()) ? rx_q[base + i] : 8'hxx;
            check($sformatf("%s_byte%0d", name, i), {24'h0, a}, {24'h0, exp[i]});
        end
    endtask

    task automatic expect_powerup(input string name);
`ifdef AMIGA_KBD_POWERUP_EN
        int base = rx_q.size();
        logic [7:0] e[$];
        wait_drain(name);
        e = '{8'hFB, 8'hFD};
        check_seq(name, base, e);
`else
        check({name, "_no_powerup"}, {28'h0, fifo_level}, 0);
`endif
    endtask

    typedef struct {
        logic [1:0] t;
        logic [7:0] d;
        bit         sent;
        logic [7:0] wire_exp;
    } vec_t;

    initial begin : main
        vec_t tv[9];
        logic [7:0] e[$];
        int base, ov0, rs0;

        tv[0] = '{2'd2, 8'h45, 1'b1, 8'h8A};
        tv[1] = '{2'd2, 8'hC5, 1'b1, 8'h8B};
        tv[2] = '{2'd0, 8'h12, 1'b0, 8'h00};
        tv[3] = '{2'd1, 8'h33, 1'b0, 8'h00};
        tv[4] = '{2'd3, 8'h55, 1'b0, 8'h00};
        tv[5] = '{2'd2, 8'h80, 1'b1, 8'h01};
        tv[6] = '{2'd2, 8'h7F, 1'b1, 8'hFE};
        tv[7] = '{2'd2, 8'hFF, 1'b1, 8'hFF};
        tv[8] = '{2'd2, 8'h01, 1'b1, 8'h02};

        reset_n = 1'b0; ev_level = 1'b0; ev_type = 2'd0; ev_data = 8'h00;
        auto_ack = 1'b1; man_req = 0;
        repeat (3) @(negedge clk);
        check("rst_dat_oe", kbd_dat_oe, 0);
        check("rst_clk_oe", kbd_clk_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_no_event", fifo_level, 0);

`ifdef AMIGA_KBD_POWERUP_EN
        base = rx_q.size();
        send_ev(2'd2, 8'h45);
        wait_drain("powerup");
        e = '{8'hFB, 8'hFD, 8'h8A};
        check_seq("powerup", base, e);
`endif

        for (int i = 0; i < 9; i++) begin
            base = rx_q.size();
            send_ev(tv[i].t, tv[i].d);
            @(negedge clk);
            check($sformatf("vec%0d_fifo_level", i), fifo_level, tv[i].sent ? 1 : 0);
            wait_drain($sformatf("vec%0d", i));
            check($sformatf("vec%0d_sent", i), rx_q.size() - base, tv[i].sent ? 1 : 0);
            if (tv[i].sent && rx_q.size() > base)
                check($sformatf("vec%0d_wire", i), rx_q[base], tv[i].wire_exp);
        end
        check("kclk_low_min", lo_min, 20);
        check("kclk_low_max", lo_max, 20);

        auto_ack = 1'b0;
        base = rx_q.size();
        ov0 = ovf_cnt;
        for (int i = 0; i < 9; i++) begin
            send_ev(2'd2, 8'h20 + 8'(i));
            @(negedge clk);
        end
        @(negedge clk);
        check("ovf_not_before_10th", ovf_cnt - ov0, 0);
        send_ev(2'd2, 8'h29);
        repeat (3) @(negedge clk);
        check("ovf_pulse_10th", ovf_cnt - ov0, 1);
        check("ovf_fifo_level", fifo_level, 8);
        wait_rx("ovf_first", base + 1);
        repeat (60) @(negedge clk);
        man_req++;
        auto_ack = 1'b1;
        wait_drain("ovf");
        e = '{wire_byte(8'h20), wire_byte(8'hFA)};
        for (int i = 1; i < 9; i++) e.push_back(wire_byte(8'h20 + 8'(i)));
        check_seq("ovf_order", base, e);
        check("ovf_single", ovf_cnt - ov0, 1);

        auto_ack = 1'b0;
        base = rx_q.size();
        rs0 = resync_cnt;
        send_ev(2'd2, 8'h45);
        wait_rx("resync_first", base + 1);
        repeat (1150) @(negedge clk);
        check("resync_one_bit", h_nbits, 1);
        check("resync_kdat_low", last_bit, 1);
        check("resync_no_byte", rx_q.size() - base, 1);
        man_req++;
        auto_ack = 1'b1;
        wait_drain("resync");
        check("resync_pulses", resync_cnt - rs0, 1);
        e = '{8'h8A, 8'hF3, 8'h8A};
        check_seq("resync_order", base, e);

        send_ev(2'd2, 8'h45);
        send_ev(2'd2, 8'h46);
        for (int i = 0; i < 2000 && h_nbits != 3; i++) @(negedge clk);
        check("rst_mid_reach_bit3", h_nbits, 3);
        repeat (5) @(negedge clk);
        check("rst_mid_pre_clk_oe", kbd_clk_oe, 1);
        check("rst_mid_pre_fifo", fifo_level, 1);
        reset_n = 1'b0;
        ev_level = 1'b0;
        #1;
        check("rst_mid_dat_oe", kbd_dat_oe, 0);
        check("rst_mid_clk_oe", kbd_clk_oe, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_fifo", fifo_level, 0);
        repeat (3) @(negedge clk);
        base = rx_q.size();
        reset_n = 1'b1;
        expect_powerup("rst_mid_powerup");
        wait_drain("rst_mid_after");
`ifdef AMIGA_KBD_POWERUP_EN
        check("rst_mid_nothing_else", rx_q.size() - base, 2);
`else
        check("rst_mid_nothing_sent", rx_q.size() - base, 0);
`endif

        ov0 = ovf_cnt;
        for (int r = 0; r < 6; r++) begin
            int n;
            logic [1:0] t;
            logic [7:0] d;
            e = {};
            base = rx_q.size();
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                t = 2'($urandom_range(0, 3));
                d = 8'($urandom);
                send_ev(t, d);
                if (t == 2'd2) e.push_back(wire_byte(d));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            wait_drain($sformatf("rand%0d", r));
            check_seq($sformatf("rand%0d", r), base, e);
        end
        check("rand_no_overflow", ovf_cnt - ov0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
